sar_adc_ctrl: RTL
=================

Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller; the capture-side counterpart of the team's binary-weighted DAC.
- Drives the DAC code bus and a track/hold strobe.
- Samples a single-bit analog comparator once per bit slot.
- Resolves MSB first, then presents a registered BIT_WIDTH-bit result with a one-cycle valid pulse.
- Sits between the analog front end (S/H, comparator, DAC) and the digital sample consumer.

Parameters:
- BIT_WIDTH, 16: conversion resolution; width of dac_code and result. Must be >= 2.
- SAMPLE_CYCLES, 2: cycles `sample` is held high before the first trial. Must be >= 1.
- SETTLE_CYCLES, 1: extra DAC settling cycles per bit before the comparator is sampled. Must be >= 0.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: conversion request; sampled on rising edge.
- abort, input, 1: synchronous cancel of a running conversion.
- comp, input, 1: comparator output; 1 = held input >= DAC output for current dac_code.
- dac_code, output, BIT_WIDTH: registered trial code to the DAC; LSB = bit 0.
- sample, output, 1: track/hold control; 1 = track.
- busy, output, 1: conversion in progress.
- result, output, BIT_WIDTH: last completed conversion; holds until the next completion.
- valid, output, 1: one-cycle pulse; result updated this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; dac_code=0, sample=0, busy=0, valid=0, result=0. Reset mid-conversion discards all progress.
- States: IDLE, SAMPLE, CONVERT, DONE. All outputs are registered.
- IDLE: start=1 at edge E0 -> SAMPLE. Same edge: sample=1, busy=1, dac_code=0, sample counter cleared.
- SAMPLE: lasts exactly SAMPLE_CYCLES cycles. At the last edge:
  - state -> CONVERT, sample=0;
  - bit index i=BIT_WIDTH-1, slot counter=0;
  - dac_code = 1<<(BIT_WIDTH-1).
- CONVERT: each bit slot lasts SETTLE_CYCLES+1 cycles. comp is sampled only at the slot's final edge; comp is ignored at all other edges.
  - Decision: bit i of dac_code keeps its trial value 1 if comp=1, else is cleared.
  - Same edge, if i>0: set bit i-1 of dac_code; i decrements; slot counter clears.
  - Same edge, if i=0: result <= decided code, dac_code <= decided code, valid=1, busy=0, state -> DONE.
- Latency: valid is high in the cycle following edge E0 + SAMPLE_CYCLES + BIT_WIDTH*(SETTLE_CYCLES+1). Defaults: 2+16*2 = 34 edges after the start edge.
- DONE: lasts one cycle. valid=1, dac_code holds the final code. Next edge:
  - valid=0;
  - start=1 -> SAMPLE (back-to-back; same actions as from IDLE);
  - otherwise -> IDLE with dac_code held.
- start while in SAMPLE or CONVERT: ignored, no queuing.
- abort=1 at an edge in SAMPLE or CONVERT: -> IDLE; dac_code=0, sample=0, busy=0; no valid; result unchanged. abort overrides the comp decision at the same edge.
- abort in IDLE or DONE: no effect on the transition, except that start at the same edge is suppressed and the block goes to IDLE.
- Arithmetic: no adders. Trial/decision is a bit-set/bit-clear on the dac_code register. Counters are sized for SAMPLE_CYCLES, SETTLE_CYCLES and BIT_WIDTH.

Test Plan:
- Ideal comparator model comp = (X >= dac_code), X=0xA5C3, defaults, start pulse at E0 -> busy high E0..E33, valid single pulse after E34, result=0xA5C3, dac_code trial sequence begins 0x8000, 0xC000, 0xA000, 0xB000.
- Boundaries: X=0x0000 -> result 0x0000. X=0xFFFF -> result 0xFFFF. Each at latency 34.
- Parameter sweep (BIT_WIDTH=4, SAMPLE_CYCLES=1, SETTLE_CYCLES=0), exhaustive X=0..15 -> result==X each time, latency 5 edges. Verify comp toggling off the final slot edge has no effect when SETTLE_CYCLES=2.
- Back-to-back: start held high continuously with X=0x1234 then 0x8001 -> DONE goes directly to SAMPLE; two valid pulses 35 edges apart; results 0x1234 then 0x8001.
- abort at the edge of the 5th bit decision -> IDLE next cycle, dac_code=0, no valid, result retains the prior value. start during busy is ignored, with no extra valid.
- rst_n low asynchronously (between edges) mid-CONVERT -> all outputs 0 immediately. After release, a new start converts X=0x00FF correctly.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller.
//   Holds the track/hold in track for SAMPLE_CYCLES, then resolves one bit
//   per slot (SETTLE_CYCLES+1 cycles), MSB first, by trial-setting a bit on
//   the DAC code and keeping or clearing it from the comparator.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - conversion request (ignored while busy)
//   abort        - synchronous cancel of a running conversion
//   comp         - comparator: 1 = held input >= DAC(dac_code)
//   dac_code     - registered trial code to the DAC
//   sample       - track/hold control, 1 = track
//   busy         - conversion in progress
//   result       - last completed conversion, held until the next one
//   valid        - one-cycle pulse when result updates
module sar_adc_ctrl #(
  parameter int BIT_WIDTH     = 16,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 comp,
  output logic [BIT_WIDTH-1:0] dac_code,
  output logic                 sample,
  output logic                 busy,
  output logic [BIT_WIDTH-1:0] result,
  output logic                 valid
);

  localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int SLW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int BIW = $clog2(BIT_WIDTH);

  localparam logic [SCW-1:0]       SAMP_LAST = SCW'(SAMPLE_CYCLES - 1);
  localparam logic [SLW-1:0]       SLOT_LAST = SLW'(SETTLE_CYCLES);
  localparam logic [BIW-1:0]       BIT_MSB   = BIW'(BIT_WIDTH - 1);
  localparam logic [BIT_WIDTH-1:0] MSB_TRIAL = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_DONE
  } state_t;

  state_t               state;
  logic [SCW-1:0]       samp_cnt;
  logic [SLW-1:0]       slot_cnt;
  logic [BIW-1:0]       bit_idx;
  logic [BIT_WIDTH-1:0] decided;
  logic [BIT_WIDTH-1:0] next_trial;

  // Decision is a plain overwrite of the trial bit with comp; the next trial
  // bit is then set below it. No arithmetic on the code itself.
  always_comb begin
    decided          = dac_code;
    decided[bit_idx] = comp;
    next_trial       = decided;
    if (bit_idx != '0) begin
      next_trial[bit_idx - 1'b1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dac_code <= '0;
      sample   <= 1'b0;
      busy     <= 1'b0;
      result   <= '0;
      valid    <= 1'b0;
      samp_cnt <= '0;
      slot_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        // IDLE and DONE react identically; dac_code is left holding its value
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            state    <= ST_SAMPLE;
            sample   <= 1'b1;
            busy     <= 1'b1;
            dac_code <= '0;
            samp_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_SAMPLE, ST_CONVERT: begin
          if (abort) begin
            state    <= ST_IDLE;
            dac_code <= '0;
            sample   <= 1'b0;
            busy     <= 1'b0;
          end else if (state == ST_SAMPLE) begin
            if (samp_cnt == SAMP_LAST) begin
              state    <= ST_CONVERT;
              sample   <= 1'b0;
              bit_idx  <= BIT_MSB;
              slot_cnt <= '0;
              dac_code <= MSB_TRIAL;
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end else begin
            // comp only matters on the last edge of each bit slot
            if (slot_cnt == SLOT_LAST) begin
              if (bit_idx != '0) begin
                dac_code <= next_trial;
                bit_idx  <= bit_idx - 1'b1;
                slot_cnt <= '0;
              end else begin
                dac_code <= decided;
                result   <= decided;
                valid    <= 1'b1;
                busy     <= 1'b0;
                state    <= ST_DONE;
              end
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
